// File: rtl/sram_fifo_ctrl_if.sv
// FIFO push/pop handshake, status and single-port-pair SRAM bus for sram_fifo_ctrl.
// slave = controller side, master = producer/consumer/SRAM side.
interface sram_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_WMASKS = 3
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] count;
   logic                  full;
   logic                  empty;
   logic                  sram_csb0;
   logic [NUM_WMASKS-1:0] sram_wmask0;
   logic [ADDR_WIDTH-1:0] sram_addr0;
   logic [DATA_WIDTH-1:0] sram_din0;
   logic                  sram_csb1;
   logic [ADDR_WIDTH-1:0] sram_addr1;
   logic [DATA_WIDTH-1:0] sram_dout1;

   modport slave (
      input  flush, in_valid, in_data, out_ready, sram_dout1,
      output in_ready, out_valid, out_data, count, full, empty,
             sram_csb0, sram_wmask0, sram_addr0, sram_din0, sram_csb1, sram_addr1
   );

   modport master (
      output flush, in_valid, in_data, out_ready, sram_dout1,
      input  in_ready, out_valid, out_data, count, full, empty,
             sram_csb0, sram_wmask0, sram_addr0, sram_din0, sram_csb1, sram_addr1
   );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO over a 1W/1R SRAM with a 2-entry output buffer; push-to-out_valid latency 2 cycles.
// Backpressure: in_ready registered (low at full/reset/flush); reads stall while the output buffer holds 2.
module sram_fifo_ctrl #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 27,
   parameter int NUM_WMASKS = 3
) (
   input logic             clk,
   input logic             rst,
   sram_fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_avail;
   logic [ADDR_WIDTH-1:0] r_count;
   logic                  r_in_ready;
   logic [DATA_WIDTH-1:0] r_buf [2];
   logic                  r_buf_wr;
   logic                  r_buf_rd;
   logic [1:0]            r_buf_cnt;

   logic                  w_in_ready;
   logic                  w_push;
   logic                  w_out_valid;
   logic                  w_pop;
   logic                  w_rd_issue;
   logic [ADDR_WIDTH-1:0] w_count_nxt;

   function automatic logic [ADDR_WIDTH-1:0] f_ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LP_LAST) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   assign w_in_ready  = r_in_ready & ~rst & ~bus.flush;
   assign w_push      = bus.in_valid & w_in_ready;
   assign w_out_valid = (r_buf_cnt != 2'd0) & ~rst;
   assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;
   // rd_avail only counts words written in earlier cycles, so a read never hits the word being written.
   assign w_rd_issue  = (r_rd_avail != '0) & (r_buf_cnt != 2'd2) & ~bus.flush & ~rst;
   assign w_count_nxt = bus.flush ? '0
                                  : r_count + ADDR_WIDTH'(w_push) - ADDR_WIDTH'(w_pop);

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_avail <= '0;
         r_count    <= '0;
         r_buf_wr   <= 1'b0;
         r_buf_rd   <= 1'b0;
         r_buf_cnt  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end
         if (w_rd_issue) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            r_buf_wr <= ~r_buf_wr;
         end
         if (w_pop) begin
            r_buf_rd <= ~r_buf_rd;
         end
         r_rd_avail <= r_rd_avail + ADDR_WIDTH'(w_push) - ADDR_WIDTH'(w_rd_issue);
         r_count    <= w_count_nxt;
         r_buf_cnt  <= r_buf_cnt + 2'(w_rd_issue) - 2'(w_pop);
      end
   end

   // Held low through the first cycle after reset; a same-cycle pop cannot open a slot at full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready <= 1'b0;
      end else begin
         r_in_ready <= (w_count_nxt < LP_DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd_issue) begin
         r_buf[r_buf_wr] <= bus.sram_dout1;
      end
   end

   always_comb begin
      bus.in_ready    = w_in_ready;
      bus.out_valid   = w_out_valid;
      bus.out_data    = w_out_valid ? r_buf[r_buf_rd] : '0;
      bus.count       = rst ? '0 : r_count;
      bus.full        = ~rst & (r_count == LP_DEPTH);
      bus.empty       = rst | (r_count == '0);
      bus.sram_csb0   = ~w_push;
      bus.sram_wmask0 = w_push ? '1 : '0;
      bus.sram_addr0  = w_push ? r_wr_ptr : '0;
      bus.sram_din0   = w_push ? bus.in_data : '0;
      bus.sram_csb1   = ~w_rd_issue;
      bus.sram_addr1  = w_rd_issue ? r_rd_ptr : '0;
   end

   a_no_rw_collision: assert property (@(posedge clk) disable iff (rst)
      !(!bus.sram_csb0 && !bus.sram_csb1 && bus.sram_addr0 == bus.sram_addr1));
   a_buf_bound: assert property (@(posedge clk) disable iff (rst) r_buf_cnt <= 2'd2);
   a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= LP_DEPTH);
endmodule
